weapon_ctrl: RTL and testbench

WEAPON_CTRL -- requirements
Module: weapon_ctrl

---
 rtl/weapon_ctrl_if.sv | 26 ++
 rtl/weapon_ctrl.sv | 155 +++++++++++++++
 tb/tb_weapon_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/weapon_ctrl_if.sv
// Player/weapon signal bundle for weapon_ctrl. The master drives the player
// inputs and the slave (the controller) drives the weapon sprite outputs.
interface weapon_ctrl_if #(
    parameter int W = 10
);
    logic [2:0]   type_i;
    logic [3:0]   state_CY_i;
    logic [W-1:0] pos_h_CY_i;
    logic [W-1:0] pos_v_CY_i;
    logic [3:0]   stage_i;
    logic [3:0]   state_o;
    logic [W-1:0] pos_h_o;
    logic [W-1:0] pos_v_o;
    logic         busy_o;
    logic         hit_o;

    modport master (
        output type_i, state_CY_i, pos_h_CY_i, pos_v_CY_i, stage_i,
        input  state_o, pos_h_o, pos_v_o, busy_o, hit_o
    );

    modport slave (
        input  type_i, state_CY_i, pos_h_CY_i, pos_v_CY_i, stage_i,
        output state_o, pos_h_o, pos_v_o, busy_o, hit_o
    );
endinterface

// File: rtl/weapon_ctrl.sv
// Weapon swing controller: IDLE -> SWING -> COOLDOWN sequencing with a
// latched weapon/direction and a clamped reach offset that follows the player.
module weapon_ctrl #(
    parameter int W            = 10,
    parameter int OFS_WOOD     = 20,
    parameter int OFS_BASYS    = 28,
    parameter int OFS_CAR      = 36,
    parameter int SWING_LEN    = 8,
    parameter int COOLDOWN_LEN = 4,
    parameter int H_MAX        = 639,
    parameter int V_MAX        = 479
) (
    input  logic         clk,
    input  logic         rst,
    weapon_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWING, COOLDOWN} fsm_e;

    localparam logic [3:0] EMPTY      = 4'hF;
    localparam logic [1:0] DIR_FRONT  = 2'd0;
    localparam logic [1:0] DIR_BACK   = 2'd1;
    localparam logic [1:0] DIR_LEFT   = 2'd2;
    localparam logic [1:0] DIR_RIGHT  = 2'd3;
    localparam logic [7:0] SWING_LAST = 8'(SWING_LEN - 1);
    localparam logic [7:0] COOL_LAST  = (COOLDOWN_LEN > 0) ? 8'(COOLDOWN_LEN - 1) : 8'd0;
    localparam logic [W:0] H_LIM      = (W+1)'(H_MAX);
    localparam logic [W:0] V_LIM      = (W+1)'(V_MAX);

    fsm_e         fsm_q, fsm_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [1:0]   type_q, type_d;
    logic [1:0]   dir_q, dir_d;
    logic         hit_q, hit_d;
    logic [W-1:0] pos_h_q, pos_h_d;
    logic [W-1:0] pos_v_q, pos_v_d;
    logic         stage_act;
    logic         req;
    logic [W:0]   ofs;

    function automatic logic [W:0] ofs_of(input logic [1:0] t);
        case (t)
            2'd0:    return (W+1)'(OFS_WOOD);
            2'd1:    return (W+1)'(OFS_BASYS);
            default: return (W+1)'(OFS_CAR);
        endcase
    endfunction

    function automatic logic [1:0] dir_of(input logic [3:0] s);
        case (s)
            4'hA:    return DIR_BACK;
            4'hB:    return DIR_FRONT;
            4'hC:    return DIR_LEFT;
            default: return DIR_RIGHT;
        endcase
    endfunction

    // Widened by one bit so a borrow shows up in the MSB instead of wrapping.
    function automatic logic [W-1:0] sub_clamp(input logic [W-1:0] a, input logic [W:0] b);
        logic [W:0] d;
        d = {1'b0, a} - b;
        return d[W] ? '0 : d[W-1:0];
    endfunction

    function automatic logic [W-1:0] add_clamp(input logic [W-1:0] a, input logic [W:0] b,
                                               input logic [W:0] lim);
        logic [W:0] s;
        s = {1'b0, a} + b;
        return (s > lim) ? lim[W-1:0] : s[W-1:0];
    endfunction

    assign stage_act = (bus.stage_i != 4'h0) && (bus.stage_i != 4'hF);

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        dir_d   = dir_q;
        hit_d   = 1'b0;
        pos_h_d = bus.pos_h_CY_i;
        pos_v_d = bus.pos_v_CY_i;
        req     = stage_act && (bus.type_i <= 3'd2) &&
                  (bus.state_CY_i >= 4'hA) && (bus.state_CY_i <= 4'hD);

        unique case (fsm_q)
            IDLE: begin
                if (req) begin
                    fsm_d  = SWING;
                    cnt_d  = SWING_LAST;
                    type_d = bus.type_i[1:0];
                    dir_d  = dir_of(bus.state_CY_i);
                    hit_d  = 1'b1;
                end
            end
            SWING: begin
                if (cnt_q == 8'd0) begin
                    fsm_d = (COOLDOWN_LEN == 0) ? IDLE : COOLDOWN;
                    cnt_d = COOL_LAST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            COOLDOWN: begin
                if (cnt_q == 8'd0) begin
                    fsm_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if (!stage_act) begin
            fsm_d = IDLE;
            cnt_d = 8'd0;
            hit_d = 1'b0;
        end

        // Keyed on the next state so the first visible cycle already carries the offset.
        ofs = ofs_of(type_d);
        if (fsm_d == SWING) begin
            case (dir_d)
                DIR_FRONT: pos_v_d = add_clamp(bus.pos_v_CY_i, ofs, V_LIM);
                DIR_BACK:  pos_v_d = sub_clamp(bus.pos_v_CY_i, ofs);
                DIR_LEFT:  pos_h_d = add_clamp(bus.pos_h_CY_i, ofs, H_LIM);
                default:   pos_h_d = sub_clamp(bus.pos_h_CY_i, ofs);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            cnt_q   <= 8'd0;
            type_q  <= 2'd0;
            dir_q   <= 2'd0;
            hit_q   <= 1'b0;
            pos_h_q <= bus.pos_h_CY_i;
            pos_v_q <= bus.pos_v_CY_i;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            dir_q   <= dir_d;
            hit_q   <= hit_d;
            pos_h_q <= pos_h_d;
            pos_v_q <= pos_v_d;
        end
    end

    assign bus.state_o = (fsm_q == SWING) ? {type_q, dir_q} : EMPTY;
    assign bus.busy_o  = (fsm_q != IDLE);
    assign bus.hit_o   = hit_q;
    assign bus.pos_h_o = pos_h_q;
    assign bus.pos_v_o = pos_v_q;
endmodule

// File: tb/tb_weapon_ctrl.sv
// Bench for weapon_ctrl: a fixed vector table, directed corner sequences and
// a random phase compared against a swing-age based reference model.
module tb_weapon_ctrl;
    localparam int S = 8;
    localparam int C = 4;

    logic clk;
    logic rst;
    weapon_ctrl_if #(.W(10)) bus ();

    weapon_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a swing is described only by the edge at which it was
    // accepted; every output follows from the age of that swing.
    int   m_k     = 0;
    int   m_start = -1;
    int   m_type  = 0;
    int   m_dir   = 0;
    int   e_state, e_ph, e_pv, e_busy, e_hit;

    function automatic int ofs_for(input int t);
        return (t == 0) ? 20 : (t == 1) ? 28 : 36;
    endfunction

    task automatic model_edge();
        int  age, o, st;
        bit  act, rq;
        st  = int'(bus.state_CY_i);
        act = (bus.stage_i != 4'h0) && (bus.stage_i != 4'hF);
        rq  = act && (bus.type_i <= 3'd2) && (st >= 10) && (st <= 13);
        if (rst || !act) begin
            m_start = -1;
        end else if (rq && (m_start < 0 || m_k - m_start >= S + C + 1)) begin
            m_start = m_k;
            m_type  = int'(bus.type_i);
            m_dir   = (st == 10) ? 1 : (st == 11) ? 0 : (st == 12) ? 2 : 3;
        end
        age     = (m_start < 0) ? 32'h3FFF_FFFF : m_k - m_start;
        e_state = (age < S) ? (m_type * 4 + m_dir) : 15;
        e_busy  = (age < S + C) ? 1 : 0;
        e_hit   = (age == 0) ? 1 : 0;
        e_ph    = int'(bus.pos_h_CY_i);
        e_pv    = int'(bus.pos_v_CY_i);
        if (age < S) begin
            o = ofs_for(m_type);
            case (m_dir)
                0: e_pv = (e_pv + o > 479) ? 479 : e_pv + o;
                1: e_pv = (e_pv - o < 0) ? 0 : e_pv - o;
                2: e_ph = (e_ph + o > 639) ? 639 : e_ph + o;
                default: e_ph = (e_ph - o < 0) ? 0 : e_ph - o;
            endcase
        end
        m_k++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic [3:0] stg, input logic [2:0] t,
                          input logic [3:0] s, input int ph, input int pv);
        rst            = r;
        bus.stage_i    = stg;
        bus.type_i     = t;
        bus.state_CY_i = s;
        bus.pos_h_CY_i = 10'(ph);
        bus.pos_v_CY_i = 10'(pv);
    endtask

    task automatic chk_all(input string tag, input int st, input int ph, input int pv,
                           input int busy, input int hit);
        chk({tag, "_state"}, 32'(bus.state_o), st);
        chk({tag, "_pos_h"}, 32'(bus.pos_h_o), ph);
        chk({tag, "_pos_v"}, 32'(bus.pos_v_o), pv);
        chk({tag, "_busy"},  32'(bus.busy_o),  busy);
        chk({tag, "_hit"},   32'(bus.hit_o),   hit);
    endtask

    typedef struct {
        logic       r;
        logic [3:0] stg;
        logic [2:0] t;
        logic [3:0] s;
        int         ph, pv;
        int         x_state, x_ph, x_pv, x_busy, x_hit;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Single wooden front swing, player moved near the bottom clamp mid-swing.
        tbl[0]  = '{1'b1, 4'h1, 3'd0, 4'h0, 100, 200, 15, 100, 200, 0, 0};
        tbl[1]  = '{1'b0, 4'h1, 3'd0, 4'hB, 100, 200,  0, 100, 220, 1, 1};
        tbl[2]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[3]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[4]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[5]  = '{1'b0, 4'h1, 3'd0, 4'h0, 150, 460,  0, 150, 479, 1, 0};
        tbl[6]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[7]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[8]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200,  0, 100, 220, 1, 0};
        tbl[9]  = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200, 15, 100, 200, 1, 0};
        tbl[10] = '{1'b0, 4'h1, 3'd0, 4'hB, 100, 200, 15, 100, 200, 1, 0};
        tbl[11] = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200, 15, 100, 200, 1, 0};
        tbl[12] = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200, 15, 100, 200, 1, 0};
        tbl[13] = '{1'b0, 4'h1, 3'd0, 4'h0, 100, 200, 15, 100, 200, 0, 0};
        tbl[14] = '{1'b0, 4'h1, 3'd7, 4'hA, 300, 300, 15, 300, 300, 0, 0};

        set_in(1'b1, 4'h1, 3'd0, 4'h0, 0, 0);
        tick();

        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].r, tbl[i].stg, tbl[i].t, tbl[i].s, tbl[i].ph, tbl[i].pv);
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].x_state, tbl[i].x_ph, tbl[i].x_pv,
                    tbl[i].x_busy, tbl[i].x_hit);
        end

        // Car, right, held continuously: clamp to 0 and a 13-cycle hit period.
        set_in(1'b1, 4'h5, 3'd2, 4'h0, 30, 100);
        tick();
        set_in(1'b0, 4'h5, 3'd2, 4'hD, 30, 100);
        for (int i = 0; i < 27; i++) begin
            tick();
            chk($sformatf("car%0d_hit", i), 32'(bus.hit_o), (i % 13 == 0) ? 1 : 0);
            chk($sformatf("car%0d_state", i), 32'(bus.state_o), (i % 13 < 8) ? 11 : 15);
            if (i % 13 < 8) chk($sformatf("car%0d_pos_h", i), 32'(bus.pos_h_o), 0);
        end

        // Basys left at the right edge; type change mid-swing must not alter the swing.
        set_in(1'b1, 4'h2, 3'd1, 4'h0, 620, 50);
        tick();
        set_in(1'b0, 4'h2, 3'd1, 4'hC, 620, 50);
        tick();
        chk_all("basys0", 6, 639, 50, 1, 1);
        set_in(1'b0, 4'h2, 3'd0, 4'hB, 600, 50);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all($sformatf("basys%0d", i), 6, 628, 50, 1, 0);
        end
        tick();
        chk_all("basys_end", 15, 600, 50, 1, 0);

        // Stage goes inactive on swing cycle 3, then a request with stage 0.
        set_in(1'b1, 4'h3, 3'd0, 4'h0, 100, 200);
        tick();
        set_in(1'b0, 4'h3, 3'd0, 4'hA, 100, 200);
        tick();
        chk_all("stg_start", 1, 100, 180, 1, 1);
        set_in(1'b0, 4'h3, 3'd0, 4'h0, 100, 200);
        tick();
        tick();
        set_in(1'b0, 4'hF, 3'd0, 4'h0, 100, 200);
        tick();
        chk_all("stg_off", 15, 100, 200, 0, 0);
        set_in(1'b0, 4'h0, 3'd0, 4'hB, 100, 200);
        tick();
        chk_all("stg0_req", 15, 100, 200, 0, 0);
        tick();
        chk_all("stg0_req2", 15, 100, 200, 0, 0);

        // Invalid type, then reset in the middle of cooldown.
        set_in(1'b0, 4'h4, 3'd5, 4'hA, 200, 200);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("badtype%0d", i), 15, 200, 200, 0, 0);
        end
        set_in(1'b0, 4'h4, 3'd0, 4'hA, 200, 200);
        tick();
        set_in(1'b0, 4'h4, 3'd0, 4'h0, 200, 200);
        for (int i = 0; i < 9; i++) tick();
        chk_all("cool_mid", 15, 200, 200, 1, 0);
        set_in(1'b1, 4'h4, 3'd0, 4'hA, 210, 220);
        tick();
        chk_all("rst_cool", 15, 210, 220, 0, 0);
        set_in(1'b0, 4'h4, 3'd0, 4'hD, 100, 220);
        tick();
        chk_all("after_rst", 3, 80, 220, 1, 1);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 2000; i++) begin
            rst            = ($urandom_range(0, 63) == 0);
            bus.stage_i    = ($urandom_range(0, 15) == 0) ?
                             (($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF) :
                             4'($urandom_range(1, 14));
            bus.type_i     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) :
                                                           3'($urandom_range(0, 2));
            bus.state_CY_i = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) :
                                                           4'($urandom_range(10, 13));
            bus.pos_h_CY_i = 10'($urandom_range(0, 1023));
            bus.pos_v_CY_i = 10'($urandom_range(0, 1023));
            tick();
            chk_all($sformatf("rnd%0d", i), e_state, e_ph, e_pv, e_busy, e_hit);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
